// File: rtl/sensor_request.sv
// sensor_request: vehicle-detector front end for the intersection controller.
// Three independent channels (0 = Norton Norte, 1 = Norton Sur, 2 = Thevenin).
// Each channel synchronizes its raw loop input and debounces it. It then latches
// a request that holds until the approach's light is sampled green.
module sensor_request #(
  parameter int DEBOUNCE_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loop_NN,
  input  logic       loop_NS,
  input  logic       loop_TH,
  input  logic [1:0] Semaforo_NN,
  input  logic [1:0] Semaforo_NS,
  input  logic [1:0] Semaforo_TH,
  output logic       SNN,
  output logic       SNS,
  output logic       STH
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] QUALIFY = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;
  localparam logic [1:0] SERVED  = 2'd3;

  localparam logic [1:0]  GREEN    = 2'b10;
  // Last qualify count before a request is raised. DEBOUNCE_TICKS <= 65535 keeps this within 16 bits.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_TICKS - 1);

  logic [2:0] loop_vec;
  logic [1:0] light_vec [3];
  logic [2:0] req_vec;

  assign loop_vec     = {loop_TH, loop_NS, loop_NN};
  assign light_vec[0] = Semaforo_NN;
  assign light_vec[1] = Semaforo_NS;
  assign light_vec[2] = Semaforo_TH;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
      logic        s1_reg;
      logic        s2_reg;
      logic [1:0]  state_reg;
      logic [1:0]  state_next;
      logic [15:0] cnt_reg;
      logic [15:0] cnt_next;
      logic        is_green;

      // Light codes come from the same clock domain, so they are used directly.
      assign is_green = (light_vec[gi] == GREEN);

      // Two-flop synchronizer for the asynchronous loop detector.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= loop_vec[gi];
          s2_reg <= s1_reg;
        end
      end

      // Next-state logic. Green is checked first and overrides every other transition.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (is_green) begin
          state_next = SERVED;
          cnt_next   = 16'd0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (s2_reg) begin
                state_next = QUALIFY;
                cnt_next   = 16'd1;
              end
            end
            QUALIFY: begin
              if (!s2_reg) begin
                state_next = IDLE;
                cnt_next   = 16'd0;
              end else if (cnt_reg == CNT_LAST) begin
                state_next = PENDING;
              end else begin
                cnt_next = cnt_reg + 16'd1;
              end
            end
            PENDING: begin
              // A vehicle leaving does not withdraw the request. Only green clears it.
              state_next = PENDING;
            end
            default: begin
              // SERVED: re-qualify from scratch once green ends.
              state_next = IDLE;
            end
          endcase
        end
      end

      // State and qualify counter registers.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg <= IDLE;
          cnt_reg   <= 16'd0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // The request is decoded from the state register. It is high only in PENDING.
      assign req_vec[gi] = (state_reg == PENDING);
    end
  endgenerate

  assign SNN = req_vec[0];
  assign SNS = req_vec[1];
  assign STH = req_vec[2];

endmodule

// File: tb/tb_sensor_request.sv
// tb_sensor_request: scoreboard bench for sensor_request with DEBOUNCE_TICKS=4.
// Expected {SNN,SNS,STH} per edge are queued with the stimulus.
// They are then popped and compared 1 ns after each rising edge.
module tb_sensor_request;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       loop_NN, loop_NS, loop_TH;
  logic [1:0] Semaforo_NN, Semaforo_NS, Semaforo_TH;
  logic       SNN, SNS, STH;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [2:0] exp_q [$];

  sensor_request #(.DEBOUNCE_TICKS(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .loop_NN     (loop_NN),
    .loop_NS     (loop_NS),
    .loop_TH     (loop_TH),
    .Semaforo_NN (Semaforo_NN),
    .Semaforo_NS (Semaforo_NS),
    .Semaforo_TH (Semaforo_TH),
    .SNN         (SNN),
    .SNS         (SNS),
    .STH         (STH)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h required=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Queue n expected vectors. Edge k (1-based) expects base, plus rise_bits when rise_at != 0 and k >= rise_at.
  task automatic push_phase(input int n, input int rise_at, input logic [2:0] rise_bits,
                            input logic [2:0] base);
    for (int k = 1; k <= n; k++) begin
      if (rise_at != 0 && k >= rise_at) exp_q.push_back(base | rise_bits);
      else                              exp_q.push_back(base);
    end
  endtask

  // Clock out every queued expectation, one edge per entry.
  task automatic drain(input string tag);
    int k;
    logic [2:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      k++;
      e = exp_q.pop_front();
      check_val($sformatf("%s e%0d", tag, k), {29'd0, SNN, SNS, STH}, {29'd0, e});
    end
  endtask

  // Serve everything and return all channels to IDLE with loops low.
  task automatic flush_all(input string tag);
    loop_NN = 0; loop_NS = 0; loop_TH = 0;
    Semaforo_NN = 2'b10; Semaforo_NS = 2'b10; Semaforo_TH = 2'b10;
    push_phase(2, 0, 3'b000, 3'b000);
    drain({tag, " green"});
    Semaforo_NN = 2'b00; Semaforo_NS = 2'b00; Semaforo_TH = 2'b00;
    push_phase(3, 0, 3'b000, 3'b000);
    drain({tag, " red"});
  endtask

  initial begin
    reset = 0;
    loop_NN = 0; loop_NS = 0; loop_TH = 0;
    Semaforo_NN = 2'b00; Semaforo_NS = 2'b00; Semaforo_TH = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("reset outs", {29'd0, SNN, SNS, STH}, 32'd0);
    check_val("reset cnt0", {16'd0, dut.gen_ch[0].cnt_reg}, 32'd0);
    check_val("reset st2", {30'd0, dut.gen_ch[2].state_reg}, 32'd0);
    reset = 1;

    // Debounce: TH held high, request after edge D+2 = 6
    loop_TH = 1;
    push_phase(8, D + 2, 3'b001, 3'b000);
    drain("debounce");
    flush_all("clean1");

    // Glitch: NN high for exactly D-1 = 3 edges is rejected
    loop_NN = 1;
    push_phase(3, 0, 3'b000, 3'b000);
    drain("glitch hi");
    loop_NN = 0;
    push_phase(6, 0, 3'b000, 3'b000);
    drain("glitch lo");
    check_val("glitch cnt", {16'd0, dut.gen_ch[0].cnt_reg}, 32'd0);
    check_val("glitch idle", {30'd0, dut.gen_ch[0].state_reg}, 32'd0);

    // Latch and serve on NS
    loop_NS = 1;
    push_phase(D + 2, D + 2, 3'b010, 3'b000);
    drain("ns qualify");
    loop_NS = 0;
    push_phase(5, 0, 3'b000, 3'b010);
    drain("ns held");
    Semaforo_NS = 2'b11;           // code 11 is not green
    push_phase(2, 0, 3'b000, 3'b010);
    drain("ns code11");
    Semaforo_NS = 2'b10;
    loop_NS = 1;
    push_phase(4, 0, 3'b000, 3'b000);
    drain("ns green");
    Semaforo_NS = 2'b00;
    push_phase(D + 3, D + 1, 3'b010, 3'b000);
    drain("ns rearm");
    flush_all("clean2");

    // Green during qualify: green applied while cnt = 2
    loop_NN = 1;
    push_phase(4, 0, 3'b000, 3'b000);
    drain("gq pre");
    check_val("gq cnt2", {16'd0, dut.gen_ch[0].cnt_reg}, 32'd2);
    Semaforo_NN = 2'b10;
    push_phase(8, 0, 3'b000, 3'b000);
    drain("gq green");
    Semaforo_NN = 2'b00;
    push_phase(D + 2, D + 1, 3'b100, 3'b000);
    drain("gq after");
    flush_all("clean3");

    // Green on the same edge as the QUALIFY->PENDING condition
    loop_NN = 1;
    push_phase(5, 0, 3'b000, 3'b000);
    drain("gp pre");
    Semaforo_NN = 2'b10;
    push_phase(3, 0, 3'b000, 3'b000);
    drain("gp green");
    flush_all("clean4");

    // Simultaneous: all three rise on the same edge
    loop_NN = 1; loop_NS = 1; loop_TH = 1;
    push_phase(D + 3, D + 2, 3'b111, 3'b000);
    drain("simul");

    // Reset mid-PENDING, asserted between edges
    #3;
    reset = 0;
    #1;
    check_val("async rst", {29'd0, SNN, SNS, STH}, 32'd0);
    @(posedge clk);
    #1;
    check_val("rst held", {29'd0, SNN, SNS, STH}, 32'd0);
    reset = 1;
    push_phase(D + 3, D + 2, 3'b111, 3'b000);
    drain("post rst");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
